score_display_engine: RTL and testbench

- Upstream feeder for the pixel colour stage.
- Accumulates the Pac-Man score from pellet and power-pellet events.
- Once per video frame, converts the binary score to six BCD digits with a sequential double-dabble FSM.
- Drives the per-pixel scoreboard_sprite / is_scoreboard pair for the current DrawX/DrawY. The digit glyph row is computed downstream as (DrawY+6)%12.

---
 rtl/score_display_engine.sv | 210 +++++++++++++++++++++
 tb/tb_score_display_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_display_engine.sv
`default_nettype none
//============================================================================
// Module   : score_display_engine
// Purpose  : Accumulates the Pac-Man score from pellet/power-pellet events,
//            converts it once per video frame to six BCD digits with a
//            sequential double-dabble FSM, and decodes the current pixel into
//            the scoreboard glyph index for the colour stage.
// Ports    : Clk, Reset_n        - system clock, async active-low reset
//            frame_clk           - vsync-rate strobe, asynchronous to Clk
//            DrawX, DrawY        - current pixel coordinates
//            pellet_eaten        - +10 points pulse
//            power_eaten         - +50 points pulse
//            score_clear         - synchronous score clear (wins over adds)
//            score               - binary running score (saturating)
//            busy                - conversion in progress
//            is_scoreboard       - pixel lies in a visible digit cell
//            scoreboard_sprite   - glyph index 0-9 for that cell
// Revision : 1.0 - initial release
//============================================================================
module score_display_engine #(
    parameter int SCORE_X0  = 72,
    parameter int SCORE_Y0  = 30,
    parameter int SCORE_MAX = 999999
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        pellet_eaten,
    input  logic        power_eaten,
    input  logic        score_clear,
    output logic [19:0] score,
    output logic        busy,
    output logic        is_scoreboard,
    output logic [3:0]  scoreboard_sprite
);

    localparam logic [1:0]  c_IDLE   = 2'd0;
    localparam logic [1:0]  c_SHIFT  = 2'd1;
    localparam logic [1:0]  c_COMMIT = 2'd2;

    localparam logic [20:0] c_MAX    = 21'(SCORE_MAX);
    localparam logic [9:0]  c_X0     = 10'(SCORE_X0);
    localparam logic [9:0]  c_X1     = 10'(SCORE_X0 + 72);
    localparam logic [9:0]  c_Y0     = 10'(SCORE_Y0);
    localparam logic [9:0]  c_Y1     = 10'(SCORE_Y0 + 12);

    logic [19:0] r_score;
    logic [1:0]  r_state;
    logic [19:0] r_bin;
    logic [23:0] r_bcd;
    logic [4:0]  r_cnt;
    logic [23:0] r_digits;
    logic        r_pending;
    logic        r_fsync1;
    logic        r_fsync2;
    logic        r_fsync3;

    logic [20:0] w_sum;
    logic [19:0] w_score_next;
    logic        w_frame_edge;
    logic [23:0] w_bcd_adj;

    //------------------------------------------------------------------
    // Score accumulator: 21-bit sum so a saturating add can never wrap.
    //------------------------------------------------------------------
    always_comb begin
        w_sum = {1'b0, r_score}
              + (pellet_eaten ? 21'd10 : 21'd0)
              + (power_eaten  ? 21'd50 : 21'd0);
        w_score_next = (w_sum > c_MAX) ? c_MAX[19:0] : w_sum[19:0];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_score <= 20'd0;
        end else if (score_clear) begin
            r_score <= 20'd0;
        end else begin
            r_score <= w_score_next;
        end
    end

    //------------------------------------------------------------------
    // frame_clk crosses into Clk through two flops; the third flop only
    // holds the previous synchronised level for rising-edge detection.
    //------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fsync1 <= 1'b0;
            r_fsync2 <= 1'b0;
            r_fsync3 <= 1'b0;
        end else begin
            r_fsync1 <= frame_clk;
            r_fsync2 <= r_fsync1;
            r_fsync3 <= r_fsync2;
        end
    end

    assign w_frame_edge = r_fsync2 & ~r_fsync3;

    //------------------------------------------------------------------
    // Double-dabble correction: every nibble >= 5 gets +3 before shift.
    //------------------------------------------------------------------
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < 6; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    //------------------------------------------------------------------
    // Conversion FSM. Digits are only written in COMMIT so a frame never
    // shows a half-converted value. A pending request restarts directly
    // from COMMIT without passing through IDLE.
    //------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= c_IDLE;
            r_bin     <= 20'd0;
            r_bcd     <= 24'd0;
            r_cnt     <= 5'd0;
            r_digits  <= 24'd0;
            r_pending <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_frame_edge) begin
                        r_bin   <= r_score;
                        r_bcd   <= 24'd0;
                        r_cnt   <= 5'd0;
                        r_state <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj[22:0], r_bin, 1'b0};
                    r_cnt          <= r_cnt + 5'd1;
                    if (r_cnt == 5'd19) begin
                        r_state <= c_COMMIT;
                    end
                    if (w_frame_edge) begin
                        r_pending <= 1'b1;
                    end
                end
                c_COMMIT: begin
                    r_digits <= r_bcd;
                    if (r_pending || w_frame_edge) begin
                        r_pending <= 1'b0;
                        r_bin     <= r_score;
                        r_bcd     <= 24'd0;
                        r_cnt     <= 5'd0;
                        r_state   <= c_SHIFT;
                    end else begin
                        r_state   <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign score = r_score;
    assign busy  = (r_state != c_IDLE);

    //------------------------------------------------------------------
    // Pixel decode. Cell 0 is the most significant digit. A cell is
    // shown once any digit at or left of it is non-zero; the two
    // rightmost cells always show so zero reads as "00".
    //------------------------------------------------------------------
    logic [9:0] w_dx;
    logic       w_in_x;
    logic       w_in_y;
    logic [2:0] w_cell;
    logic [3:0] w_dig [0:5];
    logic [5:0] w_show;
    logic       w_lead;

    assign w_dx   = DrawX - c_X0;
    assign w_in_x = (DrawX >= c_X0) && (DrawX < c_X1);
    assign w_in_y = (DrawY >= c_Y0) && (DrawY < c_Y1);

    always_comb begin
        w_cell = 3'd5;
        for (int k = 4; k >= 0; k--) begin
            if (w_dx < 10'(12 * (k + 1))) begin
                w_cell = 3'(k);
            end
        end
    end

    always_comb begin
        w_lead = 1'b0;
        w_show = 6'b0;
        for (int i = 0; i < 6; i++) begin
            w_dig[i]  = r_digits[23 - 4*i -: 4];
            w_lead    = w_lead | (w_dig[i] != 4'd0);
            w_show[i] = w_lead | (i >= 4);
        end
    end

    assign is_scoreboard     = w_in_x & w_in_y & w_show[w_cell];
    assign scoreboard_sprite = is_scoreboard ? w_dig[w_cell] : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_score_display_engine.sv
`default_nettype none
//============================================================================
// Module   : tb_score_display_engine
// Purpose  : Directed self-checking bench for score_display_engine.
// Revision : 1.0 - initial release
//============================================================================
module tb_score_display_engine;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic        pellet_eaten = 1'b0;
    logic        power_eaten = 1'b0;
    logic        score_clear = 1'b0;
    logic [19:0] score;
    logic        busy;
    logic        is_scoreboard;
    logic [3:0]  scoreboard_sprite;

    int n_tests = 0;
    int n_fail  = 0;

    score_display_engine #(
        .SCORE_X0 (72),
        .SCORE_Y0 (30),
        .SCORE_MAX(999999)
    ) u_dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .frame_clk        (frame_clk),
        .DrawX            (DrawX),
        .DrawY            (DrawY),
        .pellet_eaten     (pellet_eaten),
        .power_eaten      (power_eaten),
        .score_clear      (score_clear),
        .score            (score),
        .busy             (busy),
        .is_scoreboard    (is_scoreboard),
        .scoreboard_sprite(scoreboard_sprite)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse(input logic pel, input logic pow);
        pellet_eaten = pel;
        power_eaten  = pow;
        tick();
        pellet_eaten = 1'b0;
        power_eaten  = 1'b0;
    endtask

    // Probe the middle of cell i and compare visibility and glyph.
    task automatic check_cell(input int i, input logic vis, input logic [3:0] dig);
        DrawX = 10'(72 + 12 * i + 5);
        DrawY = 10'd35;
        #1;
        chk($sformatf("cell%0d_vis", i), 32'(is_scoreboard), 32'(vis));
        chk($sformatf("cell%0d_dig", i), 32'(scoreboard_sprite), vis ? 32'(dig) : 32'd0);
    endtask

    task automatic do_frame();
        int n;
        frame_clk = 1'b1;
        n = 0;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        chk("frame_start", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        chk("frame_done", 32'(busy), 32'd0);
        frame_clk = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int len;
        int n;

        // ---------------- reset ----------------
        repeat (3) tick();
        DrawX = 10'd132;
        DrawY = 10'd30;
        #1;
        chk("rst_held_vis", 32'(is_scoreboard), 32'd1);
        Reset_n = 1'b1;
        tick();
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        DrawX = 10'd132;
        DrawY = 10'd30;
        #1;
        chk("rst_c5_vis", 32'(is_scoreboard), 32'd1);
        chk("rst_c5_dig", 32'(scoreboard_sprite), 32'd0);
        DrawX = 10'd72;
        #1;
        chk("rst_c0_blank", 32'(is_scoreboard), 32'd0);
        // window edges around cell 5
        DrawX = 10'd143; DrawY = 10'd41; #1;
        chk("edge_in", 32'(is_scoreboard), 32'd1);
        DrawX = 10'd144; #1;
        chk("edge_right", 32'(is_scoreboard), 32'd0);
        DrawX = 10'd143; DrawY = 10'd42; #1;
        chk("edge_below", 32'(is_scoreboard), 32'd0);
        DrawY = 10'd29; #1;
        chk("edge_above", 32'(is_scoreboard), 32'd0);

        // ---------------- accumulation ----------------
        repeat (3) pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        chk("acc_score", 32'(score), 32'd140);
        do_frame();
        check_cell(0, 1'b0, 4'd0);
        check_cell(1, 1'b0, 4'd0);
        check_cell(2, 1'b0, 4'd0);
        check_cell(3, 1'b1, 4'd1);
        check_cell(4, 1'b1, 4'd4);
        check_cell(5, 1'b1, 4'd0);

        // ---------------- saturation ----------------
        score_clear = 1'b1;
        tick();
        score_clear = 1'b0;
        power_eaten = 1'b1;
        repeat (19999) tick();
        power_eaten = 1'b0;
        repeat (4) pulse(1'b1, 1'b0);
        chk("sat_preload", 32'(score), 32'd999990);
        pulse(1'b1, 1'b1);
        chk("sat_both", 32'(score), 32'd999999);
        pulse(1'b1, 1'b0);
        chk("sat_hold", 32'(score), 32'd999999);
        do_frame();
        for (int i = 0; i < 6; i++) begin
            check_cell(i, 1'b1, 4'd9);
        end

        // ---------------- clear priority ----------------
        score_clear  = 1'b1;
        pellet_eaten = 1'b1;
        tick();
        score_clear  = 1'b0;
        pellet_eaten = 1'b0;
        chk("clr_prio", 32'(score), 32'd0);

        // ---------------- pending ----------------
        repeat (3) pulse(1'b0, 1'b1);
        chk("pend_pre", 32'(score), 32'd150);
        frame_clk = 1'b1;
        n = 0;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        chk("pend_start", 32'(busy), 32'd1);
        len = 1;
        while (busy && len < 100) begin
            tick();
            if (busy) len++;
            // stimulus keyed to the first conversion's iteration count
            if (len == 5)  frame_clk = 1'b0;
            if (len == 10) frame_clk = 1'b1;
            score_clear = (len == 11);
            power_eaten = (len >= 12 && len <= 16);
            if (len == 30 && busy) begin
                check_cell(2, 1'b0, 4'd0);
                check_cell(3, 1'b1, 4'd1);
                check_cell(4, 1'b1, 4'd5);
            end
        end
        score_clear = 1'b0;
        power_eaten = 1'b0;
        frame_clk   = 1'b0;
        chk("pend_busy_len", 32'(len), 32'd42);
        chk("pend_score", 32'(score), 32'd250);
        repeat (3) tick();
        check_cell(2, 1'b0, 4'd0);
        check_cell(3, 1'b1, 4'd2);
        check_cell(4, 1'b1, 4'd5);
        check_cell(5, 1'b1, 4'd0);

        // ---------------- reset mid-SHIFT ----------------
        frame_clk = 1'b1;
        n = 0;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        chk("mid_start", 32'(busy), 32'd1);
        repeat (5) tick();
        Reset_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_score", 32'(score), 32'd0);
        check_cell(3, 1'b0, 4'd0);
        check_cell(4, 1'b1, 4'd0);
        check_cell(5, 1'b1, 4'd0);
        frame_clk = 1'b0;
        repeat (2) tick();
        Reset_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", 32'(busy), 32'd0);
        repeat (3) pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        chk("post_rst_score", 32'(score), 32'd160);
        do_frame();
        check_cell(2, 1'b0, 4'd0);
        check_cell(3, 1'b1, 4'd1);
        check_cell(4, 1'b1, 4'd6);
        check_cell(5, 1'b1, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
